// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the single-outstanding AXI-lite master.
package axi_lite_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_ADDR,
      ST_WR_DATA,
      ST_WR_RESP,
      ST_RD_ADDR,
      ST_RD_DATA,
      ST_RSP
   } state_e;

   localparam logic BRESP_OKAY      = 1'b0;
   localparam logic BRESP_ERR       = 1'b1;
   localparam int   DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/axi_timeout_cnt.sv
// Saturating handshake-wait counter; expired_o flags the last permitted wait cycle.
module axi_timeout_cnt #(
   parameter int TIMEOUT = 64
) (
   input  logic aclk,
   input  logic areset_n,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int            CW      = $clog2(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge aclk) begin
      if (!areset_n) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
      end else if (enable_i && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/axi_lite_master.sv
// Command/response to AXI-lite bridge: one transaction in flight, AW then W strictly
// sequential, every handshake wait bounded by TIMEOUT cycles.
module axi_lite_master
   import axi_lite_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic              aclk,
   input  logic              areset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_timeout,
   output logic              wr_en,
   output logic              chip_en,
   output logic [ADDR_W-1:0] awaddr,
   output logic              awvalid,
   input  logic              awready,
   output logic [DATA_W-1:0] wdata,
   output logic              wvalid,
   input  logic              wready,
   input  logic              bvalid,
   input  logic              bresp,
   output logic              bready,
   output logic [ADDR_W-1:0] araddr,
   output logic              arvalid,
   input  logic              arready,
   input  logic [DATA_W-1:0] rdata,
   input  logic              rvalid,
   output logic              rready
);

   state_e            state_q;
   logic              cmd_ready_q;
   logic              rsp_valid_q;
   logic [DATA_W-1:0] rsp_rdata_q;
   logic              rsp_err_q;
   logic              rsp_timeout_q;
   logic              wr_en_q;
   logic              chip_en_q;
   logic [ADDR_W-1:0] awaddr_q;
   logic              awvalid_q;
   logic [DATA_W-1:0] wdata_q;
   logic              wvalid_q;
   logic              bready_q;
   logic [ADDR_W-1:0] araddr_q;
   logic              arvalid_q;
   logic              rready_q;

   logic              hs;
   logic              in_wait;
   logic              tmo_expired;

   // Handshake of whichever channel the current wait state is blocked on.
   always_comb begin
      hs      = 1'b0;
      in_wait = 1'b1;
      case (state_q)
         ST_WR_ADDR: hs = awvalid_q & awready;
         ST_WR_DATA: hs = wvalid_q & wready;
         ST_WR_RESP: hs = bvalid & bready_q;
         ST_RD_ADDR: hs = arvalid_q & arready;
         ST_RD_DATA: hs = rvalid & rready_q;
         default:    in_wait = 1'b0;
      endcase
   end

   axi_timeout_cnt #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout (
      .aclk     (aclk),
      .areset_n (areset_n),
      .clear_i  (~in_wait | hs | tmo_expired),
      .enable_i (in_wait),
      .expired_o(tmo_expired)
   );

   always_ff @(posedge aclk) begin
      if (!areset_n) begin
         state_q       <= ST_IDLE;
         cmd_ready_q   <= 1'b1;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
         wr_en_q       <= 1'b1;
         chip_en_q     <= 1'b0;
         awaddr_q      <= '0;
         awvalid_q     <= 1'b0;
         wdata_q       <= '0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         araddr_q      <= '0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
      end else if (in_wait && !hs && tmo_expired) begin
         // A handshake on the final wait cycle wins; only a silent slave aborts.
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         bready_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b1;
         rsp_timeout_q <= 1'b1;
         rsp_valid_q   <= 1'b1;
         state_q       <= ST_RSP;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (cmd_valid && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  chip_en_q   <= 1'b1;
                  if (cmd_write) begin
                     awaddr_q  <= cmd_addr;
                     wdata_q   <= cmd_wdata;
                     awvalid_q <= 1'b1;
                     wr_en_q   <= 1'b0;
                     state_q   <= ST_WR_ADDR;
                  end else begin
                     araddr_q  <= cmd_addr;
                     arvalid_q <= 1'b1;
                     wr_en_q   <= 1'b1;
                     state_q   <= ST_RD_ADDR;
                  end
               end
            end
            ST_WR_ADDR: begin
               if (hs) begin
                  awvalid_q <= 1'b0;
                  wvalid_q  <= 1'b1;
                  state_q   <= ST_WR_DATA;
               end
            end
            ST_WR_DATA: begin
               if (hs) begin
                  wvalid_q <= 1'b0;
                  bready_q <= 1'b1;
                  state_q  <= ST_WR_RESP;
               end
            end
            ST_WR_RESP: begin
               if (hs) begin
                  bready_q      <= 1'b0;
                  rsp_err_q     <= (bresp == BRESP_ERR);
                  rsp_timeout_q <= 1'b0;
                  rsp_rdata_q   <= '0;
                  rsp_valid_q   <= 1'b1;
                  state_q       <= ST_RSP;
               end
            end
            ST_RD_ADDR: begin
               if (hs) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= ST_RD_DATA;
               end
            end
            ST_RD_DATA: begin
               if (hs) begin
                  rready_q      <= 1'b0;
                  rsp_rdata_q   <= rdata;
                  rsp_err_q     <= 1'b0;
                  rsp_timeout_q <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  state_q       <= ST_RSP;
               end
            end
            ST_RSP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  wr_en_q     <= 1'b1;
                  chip_en_q   <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = rsp_rdata_q;
   assign rsp_err     = rsp_err_q;
   assign rsp_timeout = rsp_timeout_q;
   assign wr_en       = wr_en_q;
   assign chip_en     = chip_en_q;
   assign awaddr      = awaddr_q;
   assign awvalid     = awvalid_q;
   assign wdata       = wdata_q;
   assign wvalid      = wvalid_q;
   assign bready      = bready_q;
   assign araddr      = araddr_q;
   assign arvalid     = arvalid_q;
   assign rready      = rready_q;

endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: directed vector table, reset-abort sequence and
// randomized traffic against a delay-configurable slave and a memory-level model.
`timescale 1ns/1ps
module tb_axi_lite_master;

   localparam int TMO = 8;

   logic        aclk = 1'b0;
   logic        areset_n = 1'b0;
   logic        cmd_valid = 1'b0, cmd_write = 1'b0;
   logic [31:0] cmd_addr = '0, cmd_wdata = '0;
   logic        rsp_ready = 1'b0;
   logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, bresp = 1'b0;
   logic        arready = 1'b0, rvalid = 1'b0;
   logic [31:0] rdata = '0;
   logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout, wr_en, chip_en;
   logic [31:0] rsp_rdata, awaddr, wdata, araddr;
   logic        awvalid, wvalid, bready, arvalid, rready;

   always #5 aclk = ~aclk;

   axi_lite_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
      .aclk(aclk), .areset_n(areset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .wr_en(wr_en), .chip_en(chip_en),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bresp(bresp), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rvalid(rvalid), .rready(rready)
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      int          aw_d, w_d, b_d, ar_d, r_d;
      logic        bresp;
      int          hold;
      logic        pulse;
   } txn_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        tmo;
      int          lat;
   } rsp_t;

   typedef struct {
      rsp_t r;
      int   n_aw, n_w, n_b, n_ar, n_r;
   } model_t;

   typedef struct {
      txn_t t;
      rsp_t e;
   } vec_t;

   int pass_cnt = 0;
   int total_cnt = 0;
   logic [31:0] slave_mem [logic [31:0]];
   logic [31:0] ref_mem   [logic [31:0]];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic int phase_len(input int d);
      return (d < TMO) ? d + 1 : TMO;
   endfunction

   // Memory-level prediction: a wait of d cycles costs d+1 cycles; d >= TMO aborts.
   function automatic model_t predict(input txn_t t);
      model_t m;
      m.r.rdata = '0; m.r.err = 1'b0; m.r.tmo = 1'b0; m.r.lat = 1;
      m.n_aw = 0; m.n_w = 0; m.n_b = 0; m.n_ar = 0; m.n_r = 0;
      if (t.wr) begin
         m.n_aw = phase_len(t.aw_d); m.r.lat += m.n_aw;
         if (t.aw_d >= TMO) m.r.tmo = 1'b1;
         else begin
            m.n_w = phase_len(t.w_d); m.r.lat += m.n_w;
            if (t.w_d >= TMO) m.r.tmo = 1'b1;
            else begin
               if (!t.bresp) ref_mem[t.addr] = t.data;
               m.n_b = phase_len(t.b_d); m.r.lat += m.n_b;
               if (t.b_d >= TMO) m.r.tmo = 1'b1;
               else m.r.err = t.bresp;
            end
         end
      end else begin
         m.n_ar = phase_len(t.ar_d); m.r.lat += m.n_ar;
         if (t.ar_d >= TMO) m.r.tmo = 1'b1;
         else begin
            m.n_r = phase_len(t.r_d); m.r.lat += m.n_r;
            if (t.r_d >= TMO) m.r.tmo = 1'b1;
            else m.r.rdata = ref_mem.exists(t.addr) ? ref_mem[t.addr] : 32'h0;
         end
      end
      if (m.r.tmo) m.r.err = 1'b1;
      return m;
   endfunction

   function automatic vec_t mk(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                               input int aw_d, input int w_d, input int b_d, input logic br,
                               input int ar_d, input int r_d, input int hold, input logic pulse,
                               input logic [31:0] e_rd, input logic e_err, input logic e_tmo,
                               input int e_lat);
      vec_t v;
      v.t.wr = wr; v.t.addr = addr; v.t.data = data;
      v.t.aw_d = aw_d; v.t.w_d = w_d; v.t.b_d = b_d; v.t.bresp = br;
      v.t.ar_d = ar_d; v.t.r_d = r_d; v.t.hold = hold; v.t.pulse = pulse;
      v.e.rdata = e_rd; v.e.err = e_err; v.e.tmo = e_tmo; v.e.lat = e_lat;
      return v;
   endfunction

   task automatic chk_reset(input string name);
      chk(name, {cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready,
                 wr_en, chip_en, rsp_err, rsp_timeout}, 11'b10000001000);
      chk({name, "_addr"}, {awaddr, araddr}, 64'h0);
      chk({name, "_data"}, {wdata, rsp_rdata}, 64'h0);
   endtask

   // Runs one command end to end, playing the slave; called and returns at a negedge.
   task automatic do_txn(input int idx, input txn_t t, input rsp_t e, input model_t m);
      int   cyc, n_aw, n_w, n_b, n_ar, n_r, aw_c, w_c, b_c, ar_c, r_c;
      logic proto_ok, hold_ok, got;
      logic [31:0] h_rdata;
      logic h_err, h_tmo;
      cyc = 0; n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
      aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
      proto_ok = 1'b1; hold_ok = 1'b1; got = 1'b0;
      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_write = t.wr; cmd_addr = t.addr; cmd_wdata = t.data;
      @(posedge aclk); cyc = 1;
      @(negedge aclk);
      if (t.pulse) begin
         cmd_write = ~t.wr; cmd_addr = ~t.addr; cmd_wdata = ~t.data;
      end else cmd_valid = 1'b0;
      while (cyc < 200 && !got) begin
         if (rsp_valid) got = 1'b1;
         else begin
            if (cmd_ready || !chip_en || (wr_en !== !t.wr) || (awvalid && wvalid)) proto_ok = 1'b0;
            if (t.wr ? (arvalid || rready) : (awvalid || wvalid || bready)) proto_ok = 1'b0;
            if (awvalid && awaddr !== t.addr) proto_ok = 1'b0;
            if (wvalid && wdata !== t.data) proto_ok = 1'b0;
            if (arvalid && araddr !== t.addr) proto_ok = 1'b0;
            if (awvalid) n_aw++;
            if (wvalid) n_w++;
            if (bready) n_b++;
            if (arvalid) n_ar++;
            if (rready) n_r++;
            awready = awvalid && (aw_c == t.aw_d); if (awvalid) aw_c++;
            wready  = wvalid && (w_c == t.w_d);    if (wvalid) w_c++;
            if (wvalid && wready && !t.bresp && !wr_en) slave_mem[awaddr] = wdata;
            bvalid  = bready && (b_c == t.b_d);    if (bready) b_c++;
            bresp   = t.bresp;
            arready = arvalid && (ar_c == t.ar_d); if (arvalid) ar_c++;
            rvalid  = rready && (r_c == t.r_d);    if (rready) r_c++;
            rdata   = rvalid ? (slave_mem.exists(araddr) ? slave_mem[araddr] : 32'h0) : $urandom;
            @(posedge aclk); cyc++;
            @(negedge aclk);
         end
      end
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
      chk("rsp_seen", got, 1);
      chk("latency", cyc, e.lat);
      chk("rsp_rdata", rsp_rdata, e.rdata);
      chk("rsp_err", rsp_err, e.err);
      chk("rsp_timeout", rsp_timeout, e.tmo);
      chk("protocol", proto_ok, 1);
      chk("phase_cycles", {n_aw[7:0], n_w[7:0], n_b[7:0], n_ar[7:0], n_r[7:0]},
          {m.n_aw[7:0], m.n_w[7:0], m.n_b[7:0], m.n_ar[7:0], m.n_r[7:0]});
      h_rdata = rsp_rdata; h_err = rsp_err; h_tmo = rsp_timeout;
      for (int h = 0; h < t.hold; h++) begin
         @(posedge aclk); @(negedge aclk);
         if (!rsp_valid || rsp_rdata !== h_rdata || rsp_err !== h_err || rsp_timeout !== h_tmo ||
             cmd_ready || !chip_en || (wr_en !== !t.wr)) hold_ok = 1'b0;
      end
      if (t.hold > 0) chk("rsp_hold", hold_ok, 1);
      rsp_ready = 1'b1; cmd_valid = 1'b0;
      @(posedge aclk); @(negedge aclk);
      rsp_ready = 1'b0;
      chk("post_idle", {rsp_valid, cmd_ready, wr_en, chip_en, awvalid, wvalid, bready, arvalid, rready},
          9'b011000000);
      $display("txn %0d %s addr=%08h data=%08h rdata=%08h err=%0d tmo=%0d lat=%0d", idx,
               t.wr ? "WR" : "RD", t.addr, t.data, h_rdata, h_err, h_tmo, cyc);
   endtask

   function automatic int rnd_d();
      return ($urandom_range(0, 9) == 0) ? int'($urandom_range(7, 9)) : int'($urandom_range(0, 3));
   endfunction

   vec_t vecs [15];

   initial begin
      txn_t   t;
      model_t m;
      int     idx;
      vecs[0]  = mk(1, 32'hFADECAFE, 32'h00001234, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 4);
      vecs[1]  = mk(0, 32'hFADECAFE, 32'h0,        0, 0, 0, 0, 0, 3, 0, 0, 32'h00001234, 0, 0, 6);
      vecs[2]  = mk(1, 32'h00000100, 32'hDEADBEEF, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0,        1, 0, 4);
      vecs[3]  = mk(0, 32'h00000100, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 3);
      vecs[4]  = mk(1, 32'h00000600, 32'h00000011, 8, 0, 0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 9);
      vecs[5]  = mk(0, 32'hFADECAFE, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 32'h00001234, 0, 0, 3);
      vecs[6]  = mk(1, 32'h00000200, 32'h0000A5A5, 7, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 11);
      vecs[7]  = mk(0, 32'h00000200, 32'h0,        0, 0, 0, 0, 7, 0, 0, 0, 32'h0000A5A5, 0, 0, 10);
      vecs[8]  = mk(0, 32'h00000200, 32'h0,        0, 0, 0, 0, 0, 8, 0, 0, 32'h0,        1, 1, 10);
      vecs[9]  = mk(1, 32'h00000300, 32'h00000077, 0, 0, 8, 0, 0, 0, 0, 0, 32'h0,        1, 1, 11);
      vecs[10] = mk(0, 32'h00000300, 32'h0,        0, 0, 0, 0, 0, 0, 5, 1, 32'h00000077, 0, 0, 3);
      vecs[11] = mk(1, 32'h00000500, 32'h00000099, 0, 9, 0, 0, 0, 0, 0, 0, 32'h0,        1, 1, 10);
      vecs[12] = mk(0, 32'h00000500, 32'h0,        0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 3);
      vecs[13] = mk(1, 32'h00000100, 32'h0000CAFE, 0, 0, 2, 0, 0, 0, 2, 1, 32'h0,        0, 0, 6);
      vecs[14] = mk(0, 32'h00000100, 32'h0,        0, 0, 0, 0, 2, 1, 0, 0, 32'h0000CAFE, 0, 0, 6);

      repeat (3) @(posedge aclk);
      @(negedge aclk);
      chk_reset("reset_state");
      areset_n = 1'b1;
      @(negedge aclk);

      idx = 0;
      for (int i = 0; i < 15; i++) begin
         m = predict(vecs[i].t);
         do_txn(idx, vecs[i].t, vecs[i].e, m);
         idx++;
      end

      // Reset while the master sits in WR_DATA waiting for wready.
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h00000400; cmd_wdata = 32'h00000055;
      @(posedge aclk); @(negedge aclk);
      cmd_valid = 1'b0;
      awready = 1'b1;
      @(posedge aclk); @(negedge aclk);
      awready = 1'b0;
      chk("wr_data_reached", {awvalid, wvalid}, 2'b01);
      areset_n = 1'b0;
      @(posedge aclk); @(negedge aclk);
      chk_reset("reset_mid_txn");
      areset_n = 1'b1;
      @(negedge aclk);
      t = vecs[5].t;
      m = predict(t);
      do_txn(idx, t, m.r, m); idx++;
      t = vecs[12].t; t.addr = 32'h00000400;
      m = predict(t);
      do_txn(idx, t, m.r, m); idx++;

      for (int i = 0; i < 40; i++) begin
         t.wr    = $urandom_range(0, 1) == 1;
         t.addr  = 32'h10 + 32'($urandom_range(0, 7)) * 4;
         t.data  = $urandom;
         t.aw_d  = rnd_d(); t.w_d = rnd_d(); t.b_d = rnd_d();
         t.ar_d  = rnd_d(); t.r_d = rnd_d();
         t.bresp = $urandom_range(0, 5) == 0;
         t.hold  = $urandom_range(0, 3);
         t.pulse = $urandom_range(0, 1) == 1;
         m = predict(t);
         do_txn(idx, t, m.r, m); idx++;
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation exceeded 1ms, checks passed %0d of %0d", pass_cnt, total_cnt);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/axi_lite_master.md
Name: axi_lite_master

Overview:
- Single-outstanding AXI-lite master that turns a simple command/response interface into AXI-lite transactions.
- Sits directly upstream of axi_sram_intf and drives all five of its channels, plus its wr_en (active-low) and chip_en sideband pins.
- Used by controllers or benches to issue single 32-bit reads and writes with a bounded-latency timeout.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
TIMEOUT, 64, cycles to wait on any AXI handshake before aborting (≥2)

Ports:
aclk  in  1  clock, all logic on rising edge
areset_n  in  1  reset; one clock; reset is synchronous and active-low
cmd_valid  in  1  command request
cmd_ready  out  1  master can accept a command
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_W  transaction address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_err  out  1  bresp error or timeout
rsp_timeout  out  1  abort due to TIMEOUT
wr_en  out  1  active-low SRAM write enable to slave
chip_en  out  1  slave chip enable
awaddr  out  ADDR_W; awvalid  out  1; awready  in  1
wdata  out  DATA_W; wvalid  out  1; wready  in  1
bvalid  in  1; bresp  in  1 (1=error); bready  out  1
araddr  out  ADDR_W; arvalid  out  1; arready  in  1
rdata  in  DATA_W; rvalid  in  1; rready  out  1

Behaviour:
- Reset (areset_n=0 at posedge): state=IDLE. All valid/ready outputs are 0, except cmd_ready=1. wr_en=1, chip_en=0. awaddr/araddr/wdata/rsp_rdata=0. rsp_err and rsp_timeout=0. Timeout counter=0.
- Reset mid-transaction aborts with no response. Outputs take reset values on the next edge.
- Outputs are registered. cmd_ready=1 only in IDLE.
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE:
  - On cmd_valid&cmd_ready, latch addr/wdata/write and set chip_en=1.
  - Write: next state WR_ADDR, awvalid=1, wr_en=0.
  - Read: next state RD_ADDR, arvalid=1, wr_en=1.
- WR_ADDR: when awvalid&awready, clear awvalid, set wvalid=1, go to WR_DATA.
- WR_DATA: when wvalid&wready, clear wvalid, set bready=1, go to WR_RESP.
- WR_RESP: when bvalid&bready, clear bready, set rsp_err=bresp, rsp_rdata=0, go to RSP.
- RD_ADDR: when arvalid&arready, clear arvalid, set rready=1, go to RD_DATA.
- RD_DATA: when rvalid&rready, capture rdata into rsp_rdata, clear rready, rsp_err=0, go to RSP.
- RSP:
  - rsp_valid=1 and held stable until rsp_ready.
  - On rsp_valid&rsp_ready: clear rsp_valid, wr_en=1, chip_en=0, cmd_ready=1, go to IDLE.
- Channel ordering: AW and W are strictly sequential, never concurrent. Only one transaction is outstanding.
- AXI valid rule: once asserted, awvalid/wvalid/arvalid and their payload stay stable until handshake or timeout.
- Timeout counter:
  - Cleared on every state entry; increments each cycle in the WR_*/RD_* states without a handshake.
  - When it reaches TIMEOUT-1 with no handshake that cycle, all AXI valid/ready outputs drop to 0 and state goes to RSP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - A handshake in the same cycle as the counter reaching TIMEOUT-1 takes priority: normal path, no timeout.
  - The counter saturates and never wraps.
- Best-case latency with zero-wait slave: write rsp_valid 4 cycles after cmd handshake; read 3 cycles.
- cmd_valid is ignored outside IDLE, with no queueing.

Decomposition:
- axi_lite_pkg: state enum (7 states), BRESP_OKAY=1'b0, BRESP_ERR=1'b1, default TIMEOUT constant.
- Sub-module axi_timeout_cnt: clear input, enable input, saturating counter, expired output. Parameter TIMEOUT, same aclk/areset_n.

Test Plan:
- Write 0x00001234 to 0xFADECAFE against a zero-wait slave responding bresp=0:
  - awvalid for 1 cycle, then wvalid for 1 cycle, then bready.
  - rsp_valid 4 cycles after cmd; rsp_err=0; wr_en=0 throughout, back to 1 after RSP.
- Read 0xFADECAFE, slave returns 0x00001234 after 3 rvalid-wait cycles: rsp_rdata=0x00001234, rsp_err=0, arvalid/araddr stable until arready.
- Write with slave returning bresp=1 (wr_en not honoured): rsp_err=1, rsp_timeout=0.
- Slave never asserts awready, TIMEOUT=8: awvalid drops after 8 cycles; rsp_valid with rsp_err=1, rsp_timeout=1; next command accepted normally.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles: rsp_valid and rsp_rdata stable, cmd_ready=0.
  - cmd_valid pulsed during the busy period: ignored.
- Reset asserted during WR_DATA: next edge all outputs at reset values and cmd_ready=1; a following read completes correctly.
